div_display_core: RTL and testbench
===================================

DIV_DISPLAY_CORE -- requirements
Module: div_display_core

Interface
REQ-001 Parameter BLINK_DIV, default 25000000, clock cycles per blink-phase toggle (0.5 s at 50 MHz); legal range 1 to 2^26-1.
REQ-002 MAX10_CLK1_50  in  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  single-cycle request to begin a division; sampled each rising edge.
REQ-005 divA  in  4  unsigned dividend; sampled when start is accepted.
REQ-006 divB  in  4  unsigned divisor; sampled when start is accepted.
REQ-007 blink_en  in  1  1 = blank all displays during blink phase 1.
REQ-008 busy  out  1  division in progress.
REQ-009 done  out  1  one-cycle pulse when a result (or error) is loaded.
REQ-010 err  out  1  last accepted division had divB = 0; held until next accepted start.
REQ-011 blink  out  1  current blink phase.
REQ-012 HEX0..HEX5  out  7 each  active-low segments; bit0=a through bit6=g; HEX5 leftmost.

Function
REQ-013 Six 5-bit digit codes drive HEX5..HEX0 through identical combinational encoders with no added latency.
REQ-014 Encoder map (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E, 16 (P)=0C, 17 (H)=09, 18 (u)=63, 20 (n)=2B; 19, 21-31 = 7F (blank).
REQ-015 Blink prescaler: counter 0..BLINK_DIV-1, increments every cycle; at terminal count it wraps to 0 and blink toggles in the same edge.
REQ-016 When blink_en=1 and blink=1, all HEX outputs = 7F; otherwise the encoder output.
REQ-017 Start is accepted only when busy=0; start while busy=1 is ignored and leaves the operation undisturbed.
REQ-018 On acceptance: busy=1 from the next cycle; divA/divB captured; later input changes have no effect.
REQ-019 Divider is restoring, one quotient bit per cycle: 4 cycles for the integer quotient Q = divA/divB, then 4 fraction digits, 4 cycles each.
REQ-020 Fraction digit k: r = 10*r_prev (8-bit), digit = r/divB, r_next = r mod divB; the first r_prev is the integer remainder.
REQ-021 Fraction digits are truncated, not rounded.
REQ-022 done pulses and busy falls exactly 21 cycles after the accepting edge; result digits update on that same edge.
REQ-023 Result layout: HEX5 = Q tens, HEX4 = Q ones (Q <= 15), HEX3..HEX0 = fraction digits 1..4; no leading-zero suppression.
REQ-024 divB = 0: no iteration, latency still 21 cycles, err=1, HEX5 = E (code 14), HEX4..HEX0 = blank (31).
REQ-025 Displayed digits hold the previous result (or blanks) while busy.
REQ-026 A start sampled in the same cycle that done pulses is ignored, since busy is still 1.

Reset
REQ-027 resetn=0 at an edge: busy=0, done=0, err=0, blink=0, prescaler=0, all digit codes=31, HEX0..HEX5=7F; reset overrides start.
REQ-028 Reset mid-division aborts the operation with no done pulse; the next start after release is accepted normally.

Verification
REQ-029 divA=7, divB=2, start pulse -> done 21 cycles later; digits 0,3,5,0,0,0; HEX5..HEX0 = 40,30,12,40,40,40; err=0.
REQ-030 divA=1, divB=7 -> digits 0,0,1,4,2,8 (truncated); divA=15, divB=1 -> 1,5,0,0,0,0; divA=10, divB=3 -> 0,3,3,3,3,3.
REQ-031 divA=9, divB=0 -> after 21 cycles err=1, HEX5=06, HEX4..HEX0=7F; next valid start clears err.
REQ-032 BLINK_DIV=4, blink_en=1 -> blink toggles every 4 cycles; HEX outputs alternate between 7F and digits; blink_en=0 -> never blanked.
REQ-033 Second start issued 5 cycles into a division with different operands -> ignored; the first result is shown after 21 cycles.
REQ-034 resetn=0 at cycle 10 of a division -> outputs at reset values and no done pulse; a fresh start completes correctly.

Source files
------------

// File: rtl/div_display_core.sv
// div_display_core
//   Divides two 4-bit unsigned operands with a restoring divider and shows the
//   result as a decimal quotient plus four truncated fraction digits on six
//   seven-segment displays. A free-running prescaler produces a blink phase
//   that can blank all displays.
//
// Ports
//   MAX10_CLK1_50 : clock, all state changes on its rising edge
//   resetn        : synchronous active-low reset
//   start         : one-cycle request to begin a division (ignored while busy)
//   divA, divB    : dividend / divisor, captured when start is accepted
//   blink_en      : blank every display while blink is 1
//   busy          : division in progress
//   done          : one-cycle pulse when the result (or error) is loaded
//   err           : the last accepted division had divB = 0
//   blink         : current blink phase
//   HEX0..HEX5    : active-low segments, bit0 = a .. bit6 = g, HEX5 leftmost
module div_display_core #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] divA,
  input  logic [3:0] divB,
  input  logic       blink_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       blink,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam logic [25:0] BLINK_LAST = 26'(BLINK_DIV - 1);
  localparam logic [4:0]  CODE_BLANK = 5'd31;
  localparam logic [4:0]  CODE_E     = 5'd14;
  localparam logic [4:0]  LAST_STEP  = 5'd20;

  logic [25:0] prescaler;
  logic [4:0]  stepCnt;
  logic [3:0]  divisorReg;
  logic [7:0]  work;
  logic [3:0]  qAcc;
  logic [3:0]  quotDigit [5];
  logic [4:0]  dispDigit [6];

  logic [1:0]  subStep;
  logic [7:0]  workIn;
  logic [7:0]  divShift;
  logic [7:0]  workNext;
  logic        geBit;
  logic        qTens;
  logic [3:0]  qOnes;
  logic        blankAll;

  function automatic logic [6:0] seg7(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:  s = 7'h40;
      5'd1:  s = 7'h79;
      5'd2:  s = 7'h24;
      5'd3:  s = 7'h30;
      5'd4:  s = 7'h19;
      5'd5:  s = 7'h12;
      5'd6:  s = 7'h02;
      5'd7:  s = 7'h78;
      5'd8:  s = 7'h00;
      5'd9:  s = 7'h10;
      5'd10: s = 7'h08;
      5'd11: s = 7'h03;
      5'd12: s = 7'h46;
      5'd13: s = 7'h21;
      5'd14: s = 7'h06;
      5'd15: s = 7'h0E;
      5'd16: s = 7'h0C;
      5'd17: s = 7'h09;
      5'd18: s = 7'h63;
      5'd20: s = 7'h2B;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Steps 0..3 produce the integer quotient from the dividend; each later
  // group of four steps produces one fraction digit from 10x the previous
  // remainder. Within a group the divisor is tried at shifts 3,2,1,0, which
  // is the restoring algorithm with the partial remainder held in place.
  always_comb begin
    subStep  = stepCnt[1:0];
    workIn   = work;
    if (subStep == 2'd0 && stepCnt != 5'd0) begin
      workIn = (work << 3) + (work << 1);
    end
    divShift = {4'b0000, divisorReg} << (2'd3 - subStep);
    geBit    = (workIn >= divShift);
    workNext = geBit ? (workIn - divShift) : workIn;
    qTens    = (quotDigit[0] >= 4'd10);
    qOnes    = qTens ? (quotDigit[0] - 4'd10) : quotDigit[0];
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!resetn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      blink     <= 1'b0;
      prescaler <= '0;
      stepCnt   <= '0;
      for (int i = 0; i < 6; i++) begin
        dispDigit[i] <= CODE_BLANK;
      end
    end else begin
      if (prescaler == BLINK_LAST) begin
        prescaler <= '0;
        blink     <= ~blink;
      end else begin
        prescaler <= prescaler + 26'd1;
      end

      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy       <= 1'b1;
          err        <= 1'b0;
          stepCnt    <= '0;
          divisorReg <= divB;
          work       <= {4'b0000, divA};
        end
      end else if (stepCnt == LAST_STEP) begin
        // Twenty-first edge after acceptance: publish the result.
        busy <= 1'b0;
        done <= 1'b1;
        if (divisorReg == 4'd0) begin
          err          <= 1'b1;
          dispDigit[5] <= CODE_E;
          for (int i = 0; i < 5; i++) begin
            dispDigit[i] <= CODE_BLANK;
          end
        end else begin
          dispDigit[5] <= {4'b0000, qTens};
          dispDigit[4] <= {1'b0, qOnes};
          dispDigit[3] <= {1'b0, quotDigit[1]};
          dispDigit[2] <= {1'b0, quotDigit[2]};
          dispDigit[1] <= {1'b0, quotDigit[3]};
          dispDigit[0] <= {1'b0, quotDigit[4]};
        end
      end else begin
        stepCnt <= stepCnt + 5'd1;
        // A zero divisor only waits out the fixed latency.
        if (divisorReg != 4'd0) begin
          work <= workNext;
          qAcc <= {qAcc[2:0], geBit};
          if (subStep == 2'd3) begin
            quotDigit[stepCnt[4:2]] <= {qAcc[2:0], geBit};
          end
        end
      end
    end
  end

  always_comb begin
    blankAll = blink_en & blink;
    HEX0 = blankAll ? 7'h7F : seg7(dispDigit[0]);
    HEX1 = blankAll ? 7'h7F : seg7(dispDigit[1]);
    HEX2 = blankAll ? 7'h7F : seg7(dispDigit[2]);
    HEX3 = blankAll ? 7'h7F : seg7(dispDigit[3]);
    HEX4 = blankAll ? 7'h7F : seg7(dispDigit[4]);
    HEX5 = blankAll ? 7'h7F : seg7(dispDigit[5]);
  end

endmodule

// File: tb/tb_div_display_core.sv
module tb_div_display_core;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [3:0] divA = 4'd0;
  logic [3:0] divB = 4'd0;
  logic       blink_en = 1'b0;
  logic       busy, done, err, blink;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int errors = 0;
  int checks = 0;

  logic [6:0] segTab [32];
  logic [6:0] expHex [6];
  logic       expErr;

  div_display_core #(.BLINK_DIV(4)) dut (
    .MAX10_CLK1_50(clk),
    .resetn(resetn),
    .start(start),
    .divA(divA),
    .divB(divB),
    .blink_en(blink_en),
    .busy(busy),
    .done(done),
    .err(err),
    .blink(blink),
    .HEX0(HEX0),
    .HEX1(HEX1),
    .HEX2(HEX2),
    .HEX3(HEX3),
    .HEX4(HEX4),
    .HEX5(HEX5)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hexAt(input int i);
    case (i)
      0: return HEX0;
      1: return HEX1;
      2: return HEX2;
      3: return HEX3;
      4: return HEX4;
      default: return HEX5;
    endcase
  endfunction

  // Expected display for a/b: quotient tens/ones, then four truncated
  // decimal fraction digits from long division.
  function automatic void model(input int a, input int b);
    int dig [6];
    int q, r;
    if (b == 0) begin
      expErr = 1'b1;
      expHex[5] = segTab[14];
      for (int i = 0; i < 5; i++) expHex[i] = segTab[31];
    end else begin
      expErr = 1'b0;
      q = a / b;
      r = a % b;
      dig[5] = q / 10;
      dig[4] = q % 10;
      for (int k = 3; k >= 0; k--) begin
        r = r * 10;
        dig[k] = r / b;
        r = r % b;
      end
      for (int i = 0; i < 6; i++) expHex[i] = segTab[dig[i]];
    end
  endfunction

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0; start = 1'b1; divA = 4'd5; divB = 4'd1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink: got %b expected 0", blink); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hexAt(i) !== 7'h7F) begin
        errors++; $display("FAIL reset_hex%0d: got %h expected 7f", i, hexAt(i));
      end
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) expHex[i] = 7'h7F;
    expErr = 1'b0;
  endtask

  // Runs one division; optionally drives a second start injectAt edges after
  // acceptance (that start is sampled on edge injectAt+1 and must be ignored).
  task automatic test_divide(input int a, input int b, input int injectAt,
                             input int a2, input int b2);
    int n;
    bit seen;
    @(negedge clk);
    divA = 4'(a); divB = 4'(b); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    divA = 4'($urandom_range(15)); divB = 4'($urandom_range(15));
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL accept_busy %0d/%0d: got %b expected 1", a, b, busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL accept_err %0d/%0d: got %b expected 0", a, b, err); end
    n = 0;
    seen = 0;
    while (!seen && n < 30) begin
      if (n == injectAt) begin
        start = 1'b1; divA = 4'(a2); divB = 4'(b2);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      if (n == 10) begin
        for (int i = 0; i < 6; i++) begin
          checks++;
          if (hexAt(i) !== expHex[i]) begin
            errors++; $display("FAIL hold_hex%0d %0d/%0d: got %h expected %h", i, a, b, hexAt(i), expHex[i]);
          end
        end
      end
    end
    start = 1'b0;
    checks++;
    if (!seen || n != 21) begin
      errors++; $display("FAIL latency %0d/%0d: got %0d expected 21", a, b, n);
    end
    model(a, b);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy %0d/%0d: got %b expected 0", a, b, busy); end
    checks++; if (err !== expErr) begin errors++; $display("FAIL err %0d/%0d: got %b expected %b", a, b, err, expErr); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hexAt(i) !== expHex[i]) begin
        errors++; $display("FAIL hex%0d %0d/%0d: got %h expected %h", i, a, b, hexAt(i), expHex[i]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse %0d/%0d: got %b expected 0", a, b, done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy %0d/%0d: got %b expected 0", a, b, busy); end
  endtask

  task automatic test_directed();
    test_divide(7, 2, -1, 0, 0);
    test_divide(1, 7, -1, 0, 0);
    test_divide(15, 1, -1, 0, 0);
    test_divide(10, 3, -1, 0, 0);
  endtask

  task automatic test_div_zero();
    test_divide(9, 0, -1, 0, 0);
    test_divide(7, 2, -1, 0, 0);
  endtask

  task automatic test_busy_ignore();
    test_divide(10, 3, 4, 1, 7);
  endtask

  task automatic test_done_start();
    test_divide(1, 7, 20, 15, 1);
  endtask

  task automatic test_reset_mid();
    int n;
    bit sawDone;
    @(negedge clk);
    divA = 4'd15; divB = 4'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (n = 1; n < 10; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hexAt(i) !== 7'h7F) begin
        errors++; $display("FAIL midreset_hex%0d: got %h expected 7f", i, hexAt(i));
      end
    end
    sawDone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) sawDone = 1;
    end
    checks++; if (sawDone) begin errors++; $display("FAIL midreset_nodone: got 1 expected 0"); end
    for (int i = 0; i < 6; i++) expHex[i] = 7'h7F;
    expErr = 1'b0;
    test_divide(15, 1, -1, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      test_divide($urandom_range(15), $urandom_range(15), -1, 0, 0);
    end
  endtask

  task automatic test_blink();
    int pc;
    bit pb;
    logic [6:0] want;
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1; blink_en = 1'b1;
    divA = 4'd7; divB = 4'd2; start = 1'b1;
    for (int i = 0; i < 6; i++) expHex[i] = 7'h7F;
    pc = 0;
    pb = 0;
    for (int n = 1; n <= 44; n++) begin
      @(posedge clk);
      if (pc == 3) begin pc = 0; pb = ~pb; end else pc++;
      @(negedge clk);
      start = 1'b0;
      if (n == 22) model(7, 2);
      checks++;
      if (blink !== pb) begin errors++; $display("FAIL blink cycle %0d: got %b expected %b", n, blink, pb); end
      for (int i = 0; i < 6; i++) begin
        want = (blink_en && pb) ? 7'h7F : expHex[i];
        checks++;
        if (hexAt(i) !== want) begin
          errors++; $display("FAIL blink_hex%0d cycle %0d: got %h expected %h", i, n, hexAt(i), want);
        end
      end
      if (n == 30) blink_en = 1'b0;
    end
  endtask

  initial begin
    segTab[0] = 7'h40; segTab[1] = 7'h79; segTab[2] = 7'h24; segTab[3] = 7'h30;
    segTab[4] = 7'h19; segTab[5] = 7'h12; segTab[6] = 7'h02; segTab[7] = 7'h78;
    segTab[8] = 7'h00; segTab[9] = 7'h10; segTab[10] = 7'h08; segTab[11] = 7'h03;
    segTab[12] = 7'h46; segTab[13] = 7'h21; segTab[14] = 7'h06; segTab[15] = 7'h0E;
    segTab[16] = 7'h0C; segTab[17] = 7'h09; segTab[18] = 7'h63; segTab[20] = 7'h2B;
    segTab[19] = 7'h7F;
    for (int i = 21; i < 32; i++) segTab[i] = 7'h7F;

    test_reset();
    test_directed();
    test_div_zero();
    test_busy_ignore();
    test_done_start();
    test_reset_mid();
    test_random();
    test_blink();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
